// File: rtl/conv1d_requant.sv
// Per-channel bias add and TFLite-style fixed-point requantization for the
// 1-D convolution CFU; four clamped int8 results are packed into one read word.
module conv1d_requant #(
    parameter int BYTE_SIZE           = 8,
    parameter int INT32_SIZE          = 32,
    parameter int MAX_OUTPUT_CHANNELS = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [6:0]            cmd,
    input  logic [INT32_SIZE-1:0] inp0,
    input  logic [INT32_SIZE-1:0] inp1,
    output logic [INT32_SIZE-1:0] ret,
    output logic                  output_buffer_valid
);

    localparam int W       = INT32_SIZE;
    localparam int W2      = 2 * INT32_SIZE;
    localparam int CH_W    = $clog2(MAX_OUTPUT_CHANNELS);
    localparam int LANES   = INT32_SIZE / BYTE_SIZE;
    localparam int LANE_W  = $clog2(LANES);
    localparam int SHIFT_W = 6;

    localparam logic [6:0] CMD_CLEAR  = 7'd0;
    localparam logic [6:0] CMD_BIAS   = 7'd50;
    localparam logic [6:0] CMD_MULT   = 7'd51;
    localparam logic [6:0] CMD_SHIFT  = 7'd52;
    localparam logic [6:0] CMD_OFFSET = 7'd53;
    localparam logic [6:0] CMD_ACTMIN = 7'd54;
    localparam logic [6:0] CMD_ACTMAX = 7'd55;
    localparam logic [6:0] CMD_PUSH   = 7'd60;
    localparam logic [6:0] CMD_RDPACK = 7'd62;
    localparam logic [6:0] CMD_RDLANE = 7'd63;

    localparam logic [W-1:0]  INT_MIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  INT_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W2-1:0] NUDGE_POS   = W2'(1) << (W - 2);
    localparam logic [W2-1:0] NUDGE_NEG   = W2'(1) - NUDGE_POS;
    localparam logic [W2-1:0] TRUNC_BIAS  = (W2'(1) << (W - 1)) - W2'(1);
    localparam logic [W-1:0]  ACT_MIN_RST = W'(-128);
    localparam logic [W-1:0]  ACT_MAX_RST = W'(127);

    // Per-channel parameter buffers (intentionally not reset).
    logic [W-1:0]       bias_q  [MAX_OUTPUT_CHANNELS];
    logic [W-1:0]       mult_q  [MAX_OUTPUT_CHANNELS];
    logic [SHIFT_W-1:0] shift_q [MAX_OUTPUT_CHANNELS];

    logic [CH_W-1:0]    cmd_ch;
    logic               cmd_push;
    logic               unused_inp0_hi;

    assign cmd_ch         = inp0[CH_W-1:0];
    assign cmd_push       = en && (cmd == CMD_PUSH);
    assign unused_inp0_hi = ^inp0[W-1:CH_W];

    // Global registers
    logic [W-1:0]      out_offset_q, out_offset_d;
    logic [W-1:0]      act_min_q, act_min_d;
    logic [W-1:0]      act_max_q, act_max_d;
    logic [W-1:0]      packed_q, packed_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [W-1:0]      ret_q, ret_d;
    logic              obv_q, obv_d;

    // Pipeline stage registers
    logic               s1_v_q, s1_v_d;
    logic [W-1:0]       s1_x_q, s1_x_d;
    logic [W-1:0]       s1_mult_q, s1_mult_d;
    logic [SHIFT_W-1:0] s1_rs_q, s1_rs_d;

    logic               s2_v_q, s2_v_d;
    logic [W2-1:0]      s2_p_q, s2_p_d;
    logic               s2_sat_q, s2_sat_d;
    logic [SHIFT_W-1:0] s2_rs_q, s2_rs_d;

    logic               s3_v_q, s3_v_d;
    logic [W-1:0]       s3_h_q, s3_h_d;
    logic [SHIFT_W-1:0] s3_rs_q, s3_rs_d;

    logic               s4_v_q, s4_v_d;
    logic [W-1:0]       s4_r_q, s4_r_d;

    // Intermediate combinational values
    logic [W-1:0]       push_sum;
    logic [SHIFT_W-1:0] push_shift;
    logic [W2-1:0]      s3_sum, s3_adj;
    logic [W2-1:0]      s4_h_ext, s4_mask, s4_rem, s4_thr;
    logic [W-1:0]       wr_sum, wr_lo;
    logic [BYTE_SIZE-1:0] wr_byte;
    logic               pipe_empty;

    always_ff @(posedge clk) begin
        if (!reset && en) begin
            case (cmd)
                CMD_BIAS:  bias_q[cmd_ch]  <= inp1;
                CMD_MULT:  mult_q[cmd_ch]  <= inp1;
                CMD_SHIFT: shift_q[cmd_ch] <= inp1[SHIFT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        push_sum   = inp1 + bias_q[cmd_ch];
        push_shift = shift_q[cmd_ch];
        pipe_empty = !(s1_v_q || s2_v_q || s3_v_q || s4_v_q);

        // S1: bias, left shift, capture multiplier and right-shift amount.
        s1_v_d    = cmd_push;
        s1_x_d    = push_shift[SHIFT_W-1] ? push_sum : (push_sum << push_shift[SHIFT_W-2:0]);
        s1_rs_d   = push_shift[SHIFT_W-1] ? (~push_shift + 6'd1) : '0;
        s1_mult_d = mult_q[cmd_ch];

        // S2: full-width signed product (sign-extended operands, low 2W bits).
        s2_v_d   = s1_v_q;
        s2_p_d   = {{W{s1_x_q[W-1]}}, s1_x_q} * {{W{s1_mult_q[W-1]}}, s1_mult_q};
        s2_sat_d = (s1_x_q == INT_MIN) && (s1_mult_q == INT_MIN);
        s2_rs_d  = s1_rs_q;

        // S3: rounding doubling high half, division truncates toward zero.
        s3_v_d  = s2_v_q;
        s3_sum  = s2_p_q + (s2_p_q[W2-1] ? NUDGE_NEG : NUDGE_POS);
        s3_adj  = s3_sum[W2-1] ? (s3_sum + TRUNC_BIAS) : s3_sum;
        s3_h_d  = s2_sat_q ? INT_MAX : W'($signed(s3_adj) >>> (W - 1));
        s3_rs_d = s2_rs_q;

        // S4: rounding arithmetic right shift, ties away from zero.
        s4_v_d   = s3_v_q;
        s4_h_ext = {{W{s3_h_q[W-1]}}, s3_h_q};
        s4_mask  = (W2'(1) << s3_rs_q) - W2'(1);
        s4_rem   = s4_h_ext & s4_mask;
        s4_thr   = (s4_mask >> 1) + {{(W2-1){1'b0}}, s3_h_q[W-1]};
        s4_r_d   = W'($signed(s4_h_ext) >>> s3_rs_q) + {{(W-1){1'b0}}, (s4_rem > s4_thr)};

        // Write stage: offset, min clamp, then max clamp so act_max wins.
        wr_sum  = s4_r_q + out_offset_q;
        wr_lo   = ($signed(wr_sum) < $signed(act_min_q)) ? act_min_q : wr_sum;
        wr_byte = ($signed(wr_lo) > $signed(act_max_q)) ? act_max_q[BYTE_SIZE-1:0]
                                                         : wr_lo[BYTE_SIZE-1:0];

        packed_d     = packed_q;
        lane_d       = lane_q;
        ret_d        = ret_q;
        out_offset_d = out_offset_q;
        act_min_d    = act_min_q;
        act_max_d    = act_max_q;

        if (s4_v_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_q == LANE_W'(i)) begin
                    packed_d[i*BYTE_SIZE +: BYTE_SIZE] = wr_byte;
                end
            end
            lane_d = lane_q + LANE_W'(1);
        end

        if (en) begin
            case (cmd)
                CMD_CLEAR: begin
                    s1_v_d   = 1'b0;
                    s2_v_d   = 1'b0;
                    s3_v_d   = 1'b0;
                    s4_v_d   = 1'b0;
                    packed_d = '0;
                    lane_d   = '0;
                end
                CMD_OFFSET: out_offset_d = inp1;
                CMD_ACTMIN: act_min_d    = inp1;
                CMD_ACTMAX: act_max_d    = inp1;
                CMD_RDPACK: begin
                    // Returns the pre-write word; clear only when nothing is in flight.
                    ret_d = packed_q;
                    if (pipe_empty) begin
                        packed_d = '0;
                        lane_d   = '0;
                    end
                end
                CMD_RDLANE: ret_d = {{(W-LANE_W){1'b0}}, lane_q};
                default: ;
            endcase
        end

        // output_buffer_valid: registered, high exactly when no stage holds a push.
        obv_d = !(s1_v_d || s2_v_d || s3_v_d || s4_v_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            s3_v_q       <= 1'b0;
            s4_v_q       <= 1'b0;
            packed_q     <= '0;
            lane_q       <= '0;
            ret_q        <= '0;
            obv_q        <= 1'b1;
            out_offset_q <= '0;
            act_min_q    <= ACT_MIN_RST;
            act_max_q    <= ACT_MAX_RST;
        end else begin
            s1_v_q       <= s1_v_d;
            s2_v_q       <= s2_v_d;
            s3_v_q       <= s3_v_d;
            s4_v_q       <= s4_v_d;
            packed_q     <= packed_d;
            lane_q       <= lane_d;
            ret_q        <= ret_d;
            obv_q        <= obv_d;
            out_offset_q <= out_offset_d;
            act_min_q    <= act_min_d;
            act_max_q    <= act_max_d;
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        s1_x_q    <= s1_x_d;
        s1_mult_q <= s1_mult_d;
        s1_rs_q   <= s1_rs_d;
        s2_p_q    <= s2_p_d;
        s2_sat_q  <= s2_sat_d;
        s2_rs_q   <= s2_rs_d;
        s3_h_q    <= s3_h_d;
        s3_rs_q   <= s3_rs_d;
        s4_r_q    <= s4_r_d;
    end

    assign ret                 = ret_q;
    assign output_buffer_valid = obv_q;

endmodule

// File: tb/tb_conv1d_requant.sv
// Directed bench for conv1d_requant: read-back values go through an expected
// queue checked by a monitor; valid-low windows are checked inline.
module tb_conv1d_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [6:0]  cmd;
    logic [31:0] inp0;
    logic [31:0] inp1;
    logic [31:0] ret;
    logic        output_buffer_valid;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          low_cnt = 0;
    logic        rd;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    conv1d_requant dut (
        .clk                 (clk),
        .reset               (reset),
        .en                  (en),
        .cmd                 (cmd),
        .inp0                (inp0),
        .inp1                (inp1),
        .ret                 (ret),
        .output_buffer_valid (output_buffer_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver: called at a falling edge, holds one command for one rising edge.
    task automatic drive(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
        en   = 1'b1;
        cmd  = c;
        inp0 = a;
        inp1 = b;
        @(negedge clk);
        en   = 1'b0;
        cmd  = 7'd0;
        inp0 = '0;
        inp1 = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] ch, input logic [31:0] acc);
        drive(7'd60, ch, acc);
    endtask

    task automatic read_exp(input logic [6:0] c, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        drive(c, 32'd0, 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!output_buffer_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, output_buffer_valid}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!output_buffer_valid) low_cnt++;
    end

    // Monitor: ret is presented one edge after an accepted 62/63.
    initial begin
        forever begin
            @(posedge clk);
            rd = en && !reset && (cmd == 7'd62 || cmd == 7'd63);
            #1;
            if (rd) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL ret_unexpected: got 0x%08h, expected no read", ret);
                end else begin
                    check(name_q.pop_front(), ret, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a push command: nothing may enter the pipeline.
        reset = 1'b1;
        en    = 1'b1;
        cmd   = 7'd60;
        inp0  = 32'd3;
        inp1  = 32'd20;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        cmd   = 7'd0;
        inp0  = '0;
        inp1  = '0;
        check("reset_ret", ret, 32'd0);
        check("reset_valid", {31'd0, output_buffer_valid}, 32'd1);
        idle(1);
        check("reset_no_push", {31'd0, output_buffer_valid}, 32'd1);
        read_exp(7'd63, 32'd0, "reset_lane");
        read_exp(7'd62, 32'd0, "reset_packed");

        // Channel 3: bias 100, mult 0.5 (Q31), shift 0 -> y = (acc+100)/2.
        drive(7'd50, 32'd3, 32'd100);
        drive(7'd51, 32'd3, 32'h4000_0000);
        drive(7'd52, 32'd3, 32'd0);

        low_cnt = 0;
        push(32'd3, 32'd20);
        wait_idle("basic_idle");
        check("basic_low_cycles", low_cnt, 32'd4);
        read_exp(7'd62, 32'h0000_003C, "basic_packed");

        low_cnt = 0;
        push(32'd3, -32'sd98);
        push(32'd3, -32'sd96);
        push(32'd3, -32'sd94);
        push(32'd3, -32'sd92);
        wait_idle("pack_idle");
        check("pack_low_cycles", low_cnt, 32'd7);
        read_exp(7'd62, 32'h0403_0201, "pack_packed");
        read_exp(7'd63, 32'd0, "pack_lane_cleared");

        // Read while busy returns a partial word and clears nothing.
        push(32'd3, -32'sd98);
        idle(3);
        push(32'd3, -32'sd96);
        read_exp(7'd62, 32'h0000_0001, "busy_partial");
        wait_idle("busy_idle");
        read_exp(7'd63, 32'd2, "busy_lane");
        read_exp(7'd62, 32'h0000_0201, "busy_full");
        read_exp(7'd63, 32'd0, "busy_lane_cleared");

        // Read on the same edge as the lane write sees the old word.
        push(32'd3, -32'sd94);
        idle(3);
        read_exp(7'd62, 32'd0, "same_edge_old");
        read_exp(7'd63, 32'd1, "same_edge_lane");
        read_exp(7'd62, 32'h0000_0003, "same_edge_new");

        // Fifth push wraps onto byte 0.
        push(32'd3, -32'sd98);
        push(32'd3, -32'sd96);
        push(32'd3, -32'sd94);
        push(32'd3, -32'sd92);
        push(32'd3, -32'sd90);
        wait_idle("wrap_idle");
        read_exp(7'd63, 32'd1, "wrap_lane");
        read_exp(7'd62, 32'h0403_0205, "wrap_packed");

        // Multiplier written right after a push only affects the next push.
        push(32'd3, -32'sd92);
        drive(7'd51, 32'd3, 32'h2000_0000);
        push(32'd3, -32'sd92);
        wait_idle("param_idle");
        read_exp(7'd62, 32'h0000_0204, "param_timing");
        drive(7'd51, 32'd3, 32'h4000_0000);

        // act_min > act_max: result is act_max.
        drive(7'd54, 32'd0, 32'd10);
        drive(7'd55, 32'd0, 32'd5);
        push(32'd3, -32'sd98);
        wait_idle("clamp_idle");
        read_exp(7'd62, 32'h0000_0005, "clamp_inverted");
        drive(7'd54, 32'd0, -32'sd128);
        drive(7'd55, 32'd0, 32'd127);

        // Positive left shift (ch6) and right shift ties (ch7).
        drive(7'd50, 32'd6, 32'd0);
        drive(7'd51, 32'd6, 32'h4000_0000);
        drive(7'd52, 32'd6, 32'd2);
        drive(7'd50, 32'd7, 32'd0);
        drive(7'd51, 32'd7, 32'h4000_0000);
        drive(7'd52, 32'd7, 32'hFFFF_FFFF);
        push(32'd6, 32'd3);
        push(32'd7, -32'sd6);
        push(32'd7, 32'd6);
        wait_idle("shift_idle");
        read_exp(7'd62, 32'h0002_FE06, "shift_rounding");

        // Negative rounding then clamp at act_min.
        drive(7'd50, 32'd0, 32'd0);
        drive(7'd51, 32'd0, 32'h4000_0000);
        drive(7'd52, 32'd0, 32'hFFFF_FFFE);
        drive(7'd53, 32'd0, -32'sd128);
        push(32'd0, -32'sd10);
        wait_idle("neg_idle");
        read_exp(7'd62, 32'h0000_0080, "neg_clamp");

        // Saturating doubling high-mul.
        drive(7'd50, 32'd5, 32'd0);
        drive(7'd51, 32'd5, 32'h8000_0000);
        drive(7'd52, 32'd5, 32'd0);
        push(32'd5, 32'h8000_0000);
        wait_idle("sat_idle");
        read_exp(7'd62, 32'h0000_007F, "saturation");

        // Clear command discards an in-flight push.
        drive(7'd53, 32'd0, 32'd0);
        push(32'd3, -32'sd98);
        drive(7'd0, 32'd0, 32'd0);
        check("clear_valid", {31'd0, output_buffer_valid}, 32'd1);
        idle(4);
        read_exp(7'd62, 32'd0, "clear_packed");
        read_exp(7'd63, 32'd0, "clear_lane");

        // Reset two cycles after a push.
        push(32'd3, -32'sd98);
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_valid", {31'd0, output_buffer_valid}, 32'd1);
        check("midreset_ret", ret, 32'd0);
        idle(4);
        read_exp(7'd62, 32'd0, "midreset_packed");
        read_exp(7'd63, 32'd0, "midreset_lane");

        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
